// File: rtl/facelet_sampler_if.sv
// Bundles the facelet sampler's control, pixel-stream and read-port signals.
// slave is the sampler side; master is the driver/consumer side.
`timescale 1ns / 1ps

interface facelet_sampler_if #(
  parameter int unsigned CW    = 8,
  parameter int unsigned IDX_W = 4
);
  logic          Execute;
  logic [9:0]    X_in;
  logic [9:0]    Y_in;
  logic [9:0]    CubeS;
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic          Pixel_valid;
  logic          Frame_start;
  logic [CW-1:0] R_in;
  logic [CW-1:0] G_in;
  logic [CW-1:0] B_in;
  logic [IDX_W-1:0] Rd_idx;
  logic [CW-1:0] Rd_R;
  logic [CW-1:0] Rd_G;
  logic [CW-1:0] Rd_B;
  logic          Busy;
  logic          Done;
  logic          Cfg_err;
  logic          Hit;

  modport slave (
    input  Execute, X_in, Y_in, CubeS, DrawX, DrawY, Pixel_valid, Frame_start,
    input  R_in, G_in, B_in, Rd_idx,
    output Rd_R, Rd_G, Rd_B, Busy, Done, Cfg_err, Hit
  );

  modport master (
    output Execute, X_in, Y_in, CubeS, DrawX, DrawY, Pixel_valid, Frame_start,
    output R_in, G_in, B_in, Rd_idx,
    input  Rd_R, Rd_G, Rd_B, Busy, Done, Cfg_err, Hit
  );
endinterface

// File: rtl/facelet_sampler.sv
// Averages RGB over a WIN x WIN window at the centre of each cell of a GRID x GRID
// cube face during one captured frame; results are read back through a registered port.
`timescale 1ns / 1ps

module facelet_sampler #(
  parameter int unsigned GRID     = 3,
  parameter int unsigned WIN_LOG2 = 2,
  parameter int unsigned CW       = 8,
  parameter int unsigned IDX_W    = 4
) (
  input logic               Clk,
  input logic               Reset_n,
  facelet_sampler_if.slave  bus
);
  localparam int unsigned NCell = GRID * GRID;
  localparam int unsigned Win   = 1 << WIN_LOG2;
  localparam int unsigned AW    = CW + 2 * WIN_LOG2;

  typedef enum logic [1:0] {StIdle, StWaitFrame, StCapture, StDone} state_e;
  state_e state_q, state_d;

  logic [9:0]    x_q, y_q, s_q;
  logic [AW-1:0] acc_r_q [NCell];
  logic [AW-1:0] acc_g_q [NCell];
  logic [AW-1:0] acc_b_q [NCell];
  logic [CW-1:0] res_r_q [NCell];
  logic [CW-1:0] res_g_q [NCell];
  logic [CW-1:0] res_b_q [NCell];
  logic [CW-1:0] rd_r_q, rd_g_q, rd_b_q;
  logic [CW-1:0] rd_r_d, rd_g_d, rd_b_d;
  logic          cfg_err_q, hit_q, armed_q;

  logic          exec_ok, exec_bad, acc_en;
  logic [11:0]   off, x_lo, y_lo, px, py;
  logic [NCell-1:0] in_win;

  always_comb begin
    exec_ok  = (state_q == StIdle) && bus.Execute && (bus.CubeS >= 10'(Win));
    exec_bad = (state_q == StIdle) && bus.Execute && (bus.CubeS < 10'(Win));
    // A pixel arriving with the closing Frame_start belongs to the next frame.
    acc_en   = (state_q == StCapture) && bus.Pixel_valid && !bus.Frame_start;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (exec_ok) state_d = StWaitFrame;
      StWaitFrame: if (bus.Frame_start) state_d = StCapture;
      StCapture:   if (bus.Frame_start) state_d = StDone;
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // 12-bit window bounds so far-off grids cannot wrap back onto the screen.
  always_comb begin
    off    = 12'(s_q >> 1) - 12'(Win >> 1);
    px     = {2'b00, bus.DrawX};
    py     = {2'b00, bus.DrawY};
    in_win = '0;
    x_lo   = '0;
    y_lo   = '0;
    for (int r = 0; r < GRID; r++) begin
      for (int c = 0; c < GRID; c++) begin
        x_lo = {2'b00, x_q} + 12'(c) * {2'b00, s_q} + off;
        y_lo = {2'b00, y_q} + 12'(r) * {2'b00, s_q} + off;
        in_win[r*GRID+c] = (px >= x_lo) && (px < x_lo + 12'(Win)) &&
                           (py >= y_lo) && (py < y_lo + 12'(Win));
      end
    end
  end

  always_comb begin
    rd_r_d = '0;
    rd_g_d = '0;
    rd_b_d = '0;
    for (int k = 0; k < NCell; k++) begin
      if (bus.Rd_idx == IDX_W'(k)) begin
        rd_r_d = res_r_q[k];
        rd_g_d = res_g_q[k];
        rd_b_d = res_b_q[k];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      s_q       <= '0;
      cfg_err_q <= 1'b0;
      armed_q   <= 1'b0;
      hit_q     <= 1'b0;
      rd_r_q    <= '0;
      rd_g_q    <= '0;
      rd_b_q    <= '0;
    end else begin
      state_q <= state_d;
      if (exec_ok) begin
        x_q       <= bus.X_in;
        y_q       <= bus.Y_in;
        s_q       <= bus.CubeS;
        cfg_err_q <= 1'b0;
        armed_q   <= 1'b1;
      end else if (exec_bad) begin
        cfg_err_q <= 1'b1;
      end
      hit_q  <= armed_q && bus.Pixel_valid && (|in_win);
      rd_r_q <= rd_r_d;
      rd_g_q <= rd_g_d;
      rd_b_q <= rd_b_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NCell; k++) begin
        acc_r_q[k] <= '0;
        acc_g_q[k] <= '0;
        acc_b_q[k] <= '0;
        res_r_q[k] <= '0;
        res_g_q[k] <= '0;
        res_b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCell; k++) begin
        if (exec_ok) begin
          acc_r_q[k] <= '0;
          acc_g_q[k] <= '0;
          acc_b_q[k] <= '0;
        end else if (acc_en && in_win[k]) begin
          acc_r_q[k] <= acc_r_q[k] + AW'(bus.R_in);
          acc_g_q[k] <= acc_g_q[k] + AW'(bus.G_in);
          acc_b_q[k] <= acc_b_q[k] + AW'(bus.B_in);
        end
        // Divide by the fixed window area, even for partly visited windows.
        if (state_q == StDone) begin
          res_r_q[k] <= acc_r_q[k][AW-1:2*WIN_LOG2];
          res_g_q[k] <= acc_g_q[k][AW-1:2*WIN_LOG2];
          res_b_q[k] <= acc_b_q[k][AW-1:2*WIN_LOG2];
        end
      end
    end
  end

  assign bus.Rd_R    = rd_r_q;
  assign bus.Rd_G    = rd_g_q;
  assign bus.Rd_B    = rd_b_q;
  assign bus.Busy    = (state_q == StWaitFrame) || (state_q == StCapture);
  assign bus.Done    = (state_q == StDone);
  assign bus.Cfg_err = cfg_err_q;
  assign bus.Hit     = hit_q;

endmodule

// File: tb/tb_facelet_sampler.sv
// Drives directed and randomized captures into facelet_sampler and compares read-back
// averages, Done/Busy/Cfg_err and Hit counts against a per-cell sum model.
`timescale 1ns / 1ps

module tb_facelet_sampler;
  localparam int GRID  = 3;
  localparam int WL    = 2;
  localparam int CW    = 8;
  localparam int IDX_W = 4;
  localparam int NC    = GRID * GRID;
  localparam int WIN   = 1 << WL;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  facelet_sampler_if #(.CW(CW), .IDX_W(IDX_W)) bus ();

  facelet_sampler #(.GRID(GRID), .WIN_LOG2(WL), .CW(CW), .IDX_W(IDX_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int hit_cnt  = 0;
  int done_cnt = 0;

  always @(negedge Clk) begin
    if (bus.Done === 1'b1) done_cnt++;
    if (bus.Hit === 1'b1) hit_cnt++;
  end

  // Reference model: 0 idle, 1 waiting for frame, 2 capturing.
  int mstate = 0;
  int mx = 0, my = 0, ms = WIN, moff = 0;
  bit armed = 0, mcfg = 0;
  int sum_r[NC], sum_g[NC], sum_b[NC];
  int res_r[NC], res_g[NC], res_b[NC];
  int prv_r[NC], prv_g[NC], prv_b[NC];
  int exp_hits = 0, exp_done = 0;
  int cr = 0, cg = 0, cb = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  function automatic int cell_of(input int x, input int y);
    int dx, dy;
    dx = x - mx - moff;
    dy = y - my - moff;
    if (dx < 0 || dy < 0) return -1;
    if (dx / ms >= GRID || dy / ms >= GRID) return -1;
    if (dx % ms >= WIN || dy % ms >= WIN) return -1;
    return (dy / ms) * GRID + (dx / ms);
  endfunction

  function automatic void model_reset();
    mstate = 0;
    armed  = 0;
    mcfg   = 0;
    for (int k = 0; k < NC; k++) begin
      sum_r[k] = 0; sum_g[k] = 0; sum_b[k] = 0;
      res_r[k] = 0; res_g[k] = 0; res_b[k] = 0;
    end
  endfunction

  function automatic void frame_edge();
    if (mstate == 1) begin
      mstate = 2;
    end else if (mstate == 2) begin
      for (int k = 0; k < NC; k++) begin
        prv_r[k] = res_r[k]; prv_g[k] = res_g[k]; prv_b[k] = res_b[k];
        res_r[k] = (sum_r[k] / (WIN * WIN)) % 256;
        res_g[k] = (sum_g[k] / (WIN * WIN)) % 256;
        res_b[k] = (sum_b[k] / (WIN * WIN)) % 256;
      end
      mstate = 0;
      exp_done++;
    end
  endfunction

  task automatic exec(input int x, input int y, input int s);
    bus.X_in    = 10'(x);
    bus.Y_in    = 10'(y);
    bus.CubeS   = 10'(s);
    bus.Execute = 1'b1;
    if (mstate == 0) begin
      if (s >= WIN) begin
        mstate = 1; mx = x; my = y; ms = s; moff = s / 2 - WIN / 2;
        armed = 1; mcfg = 0;
        for (int k = 0; k < NC; k++) begin
          sum_r[k] = 0; sum_g[k] = 0; sum_b[k] = 0;
        end
      end else begin
        mcfg = 1;
      end
    end
    step;
    bus.Execute = 1'b0;
    // Scramble the geometry inputs: the sampler must use its latched copy.
    bus.X_in  = 10'($urandom_range(0, 1023));
    bus.Y_in  = 10'($urandom_range(0, 1023));
    bus.CubeS = 10'($urandom_range(0, 1023));
    check("cfg_err_after_exec", 32'(bus.Cfg_err), 32'(mcfg));
    check("busy_after_exec", 32'(bus.Busy), 32'(mstate != 0));
  endtask

  task automatic pix(input int x, input int y, input int r, input int g, input int b,
                     input bit valid, input bit fs, input bit ex);
    int k;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.R_in        = 8'(r);
    bus.G_in        = 8'(g);
    bus.B_in        = 8'(b);
    bus.Pixel_valid = valid;
    bus.Frame_start = fs;
    bus.Execute     = ex;
    k = (valid && armed) ? cell_of(x, y) : -1;
    if (k >= 0) exp_hits++;
    if (fs) begin
      frame_edge();
    end else if (mstate == 2 && k >= 0) begin
      sum_r[k] += r; sum_g[k] += g; sum_b[k] += b;
    end
    step;
    bus.Pixel_valid = 1'b0;
    bus.Frame_start = 1'b0;
    bus.Execute     = 1'b0;
  endtask

  // Scans only the rows around the window bands, full width of the grid box.
  task automatic scan(input int mode, input int gx, input int gy, input int gs,
                      input int skx, input int sky, input int stop_after, input int ex_at);
    int off, x0, x1, y0, y1, dy, n, r, g, b;
    off = gs / 2 - WIN / 2;
    x0 = (gx + off - 1 < 0) ? 0 : gx + off - 1;
    y0 = (gy + off - 1 < 0) ? 0 : gy + off - 1;
    x1 = (gx + 2 * gs + off + WIN > 1023) ? 1023 : gx + 2 * gs + off + WIN;
    y1 = (gy + 2 * gs + off + WIN > 1023) ? 1023 : gy + 2 * gs + off + WIN;
    n = 0;
    for (int y = y0; y <= y1; y++) begin
      dy = y - gy - off;
      if (dy < -1 || (dy + 1) % gs > WIN) continue;
      for (int x = x0; x <= x1; x++) begin
        if (x == skx && y == sky) continue;
        if ($urandom_range(0, 7) == 0) step;
        case (mode)
          0:       begin r = cr; g = cg; b = cb; end
          1:       begin r = x % 256; g = 0; b = 0; end
          default: begin
            r = int'($urandom_range(0, 255));
            g = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
          end
        endcase
        pix(x, y, r, g, b, 1'b1, 1'b0, n == ex_at);
        n++;
        if (n == stop_after) return;
      end
    end
  endtask

  task automatic close_and_check(input int idx, input bit with_pix, input int x,
                                 input int y, input int v);
    int ir;
    bus.Rd_idx = 4'(idx);
    ir = (idx < NC) ? idx : 0;
    pix(x, y, v, v, v, with_pix, 1'b1, 1'b0);
    check("done_pulse", 32'(bus.Done), 32'd1);
    check("busy_in_done", 32'(bus.Busy), 32'd0);
    step;
    check("done_low", 32'(bus.Done), 32'd0);
    check("rd_old_after_done", 32'(bus.Rd_R), 32'((idx < NC) ? prv_r[ir] : 0));
    check("done_count", 32'(done_cnt), 32'(exp_done));
    check("hit_count", 32'(hit_cnt), 32'(exp_hits));
    step;
    check("rd_new_after_done", 32'(bus.Rd_R), 32'((idx < NC) ? res_r[ir] : 0));
  endtask

  task automatic read_all;
    for (int k = 0; k < 16; k++) begin
      if (k >= NC && k != 12 && k != 15) continue;
      bus.Rd_idx = 4'(k);
      step;
      check($sformatf("rd_r[%0d]", k), 32'(bus.Rd_R), 32'((k < NC) ? res_r[k] : 0));
      check($sformatf("rd_g[%0d]", k), 32'(bus.Rd_G), 32'((k < NC) ? res_g[k] : 0));
      check($sformatf("rd_b[%0d]", k), 32'(bus.Rd_B), 32'((k < NC) ? res_b[k] : 0));
    end
  endtask

  task automatic read_one(input string tag, input int k, input int exp_r);
    bus.Rd_idx = 4'(k);
    step;
    check(tag, 32'(bus.Rd_R), 32'(exp_r));
  endtask

  task automatic start_counts;
    hit_cnt  = 0;
    exp_hits = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int sx, sy, ss;
    bus.Execute = 0; bus.X_in = 0; bus.Y_in = 0; bus.CubeS = 0;
    bus.DrawX = 0; bus.DrawY = 0; bus.Pixel_valid = 0; bus.Frame_start = 0;
    bus.R_in = 0; bus.G_in = 0; bus.B_in = 0; bus.Rd_idx = 0;
    model_reset();
    for (int k = 0; k < NC; k++) begin
      prv_r[k] = 0; prv_g[k] = 0; prv_b[k] = 0;
    end

    // Reset state
    repeat (3) step;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_cfg_err", 32'(bus.Cfg_err), 32'd0);
    check("rst_hit", 32'(bus.Hit), 32'd0);
    check("rst_rd_r", 32'(bus.Rd_R), 32'd0);
    check("rst_rd_g", 32'(bus.Rd_G), 32'd0);
    check("rst_rd_b", 32'(bus.Rd_B), 32'd0);
    Reset_n = 1'b1;
    step;

    // Hit stays low before any Execute
    start_counts();
    cr = 8'h11; cg = 8'h22; cb = 8'h33;
    scan(0, 100, 80, 40, -1, -1, -1, -1);
    step;
    check("hit_unarmed", 32'(hit_cnt), 32'(exp_hits));

    // Config error then accepted Execute
    exec(100, 80, 3);
    repeat (3) step;
    check("cfg_no_done", 32'(done_cnt), 32'd0);
    check("cfg_busy_idle", 32'(bus.Busy), 32'd0);
    exec(100, 80, 40);

    // Constant colour, with a stray Execute mid-capture
    cr = 8'h20; cg = 8'h80; cb = 8'hF0;
    pix(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    start_counts();
    scan(0, 100, 80, 40, -1, -1, -1, 500);
    close_and_check(4, 1'b0, 0, 0, 0);
    check("hit_count_144", 32'(hit_cnt), 32'd144);
    read_all();

    // Gradient on R
    exec(100, 80, 40);
    pix(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    start_counts();
    scan(1, 100, 80, 40, -1, -1, -1, -1);
    close_and_check(0, 1'b0, 0, 0, 0);
    read_all();
    read_one("grad_cell0", 0, 119);
    read_one("grad_cell5", 5, 199);

    // Reset mid-capture
    exec(100, 80, 40);
    pix(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    scan(2, 100, 80, 40, -1, -1, 300, -1);
    bus.Rd_idx = 4'd5;
    step;
    Reset_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(bus.Busy), 32'd0);
    check("rstmid_rd_r", 32'(bus.Rd_R), 32'd0);
    check("rstmid_rd_g", 32'(bus.Rd_G), 32'd0);
    check("rstmid_rd_b", 32'(bus.Rd_B), 32'd0);
    check("rstmid_done", 32'(bus.Done), 32'd0);
    model_reset();
    step;
    Reset_n = 1'b1;
    step;

    // Fresh capture after the abort, random colours
    exec(100, 80, 40);
    pix(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    start_counts();
    scan(2, 100, 80, 40, -1, -1, -1, -1);
    close_and_check(8, 1'b0, 0, 0, 0);
    read_all();

    // Grid running off the right edge
    exec(1000, 80, 40);
    pix(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    start_counts();
    scan(2, 1000, 80, 40, -1, -1, -1, -1);
    close_and_check(12, 1'b0, 0, 0, 0);
    read_all();
    read_one("edge_col2", 2, 0);

    // Pixel coincident with the closing Frame_start is excluded
    exec(100, 80, 40);
    pix(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    start_counts();
    cr = 8'h10; cg = 8'h10; cb = 8'h10;
    scan(0, 100, 80, 40, 118, 98, -1, -1);
    close_and_check(0, 1'b1, 118, 98, 8'hFF);
    check("align_hit_144", 32'(hit_cnt), 32'd144);
    read_one("align_cell0", 0, 15);
    read_all();

    // Random geometry
    for (int t = 0; t < 2; t++) begin
      ss = int'($urandom_range(4, 40));
      sx = int'($urandom_range(0, 900));
      sy = int'($urandom_range(0, 300));
      exec(sx, sy, ss);
      pix(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
      start_counts();
      scan(2, sx, sy, ss, -1, -1, -1, -1);
      close_and_check(int'($urandom_range(0, 8)), 1'b0, 0, 0, 0);
      read_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
